pla_prog: RTL



---
 rtl/pla_pkg.sv | 30 +++
 rtl/pla_prog_eval.sv | 47 ++++
 rtl/pla_prog.sv | 111 +++++++++++
 3 files changed

// File: rtl/pla_pkg.sv
// Shared sizing helpers, plane offsets and FSM state type
// for the serially programmable PLA.
package pla_pkg;

    localparam int N_IN_DEF   = 3;
    localparam int N_TERM_DEF = 5;
    localparam int N_OUT_DEF  = 2;

    function automatic int fuse_w(input int n_in, input int n_term, input int n_out);
        return n_term * 2 * n_in + n_out * n_term;
    endfunction

    function automatic int frame_w(input int n_in, input int n_term, input int n_out);
        return fuse_w(n_in, n_term, n_out) + 1;
    endfunction

    function automatic int or_base(input int n_in, input int n_term);
        return n_term * 2 * n_in;
    endfunction

    localparam int AND_BASE = 0;
    localparam int OR_BASE  = or_base(N_IN_DEF, N_TERM_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/pla_prog_eval.sv
// Combinational sum-of-products evaluation from a fuse vector.
// Terms with no enabled literal are forced to 0.
module pla_eval
    import pla_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_TERM = N_TERM_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    localparam int FW    = fuse_w(N_IN, N_TERM, N_OUT),
    localparam int OR_B  = or_base(N_IN, N_TERM)
) (
    input  logic [FW-1:0]    fuse_i,
    input  logic [N_IN-1:0]  in_i,
    output logic [N_OUT-1:0] out_o
);

    logic [N_TERM-1:0] term;
    logic              en;
    logic              ok;
    logic              pos;
    logic              neg;

    always_comb begin
        term  = '0;
        out_o = '0;
        en    = 1'b0;
        ok    = 1'b1;
        pos   = 1'b0;
        neg   = 1'b0;
        for (int t = 0; t < N_TERM; t++) begin
            en = 1'b0;
            ok = 1'b1;
            for (int i = 0; i < N_IN; i++) begin
                pos = fuse_i[AND_BASE + t*2*N_IN + 2*i];
                neg = fuse_i[AND_BASE + t*2*N_IN + 2*i + 1];
                en  = en | pos | neg;
                if (pos && !in_i[i]) ok = 1'b0;
                if (neg &&  in_i[i]) ok = 1'b0;
            end
            term[t] = en & ok;
        end
        for (int o = 0; o < N_OUT; o++) begin
            out_o[o] = |(term & fuse_i[OR_B + o*N_TERM +: N_TERM]);
        end
    end

endmodule

// File: rtl/pla_prog.sv
// Serial-load PLA: parity-checked frame into a shadow map,
// atomic commit to the active map, registered outputs.
module pla_prog
    import pla_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_TERM = N_TERM_DEF,
    parameter int N_OUT  = N_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             busy,
    input  logic [N_IN-1:0]  pla_in,
    output logic [N_OUT-1:0] pla_out
);

    localparam int FW  = fuse_w(N_IN, N_TERM, N_OUT);
    localparam int FRW = frame_w(N_IN, N_TERM, N_OUT);
    localparam int CW  = $clog2(FRW + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               par_q;
    logic [FW-1:0]      shadow_q;
    logic [FW-1:0]      active_q;
    logic               ready_q;
    logic               done_q;
    logic               err_q;
    logic               busy_q;
    logic [N_OUT-1:0]   out_q;
    logic [N_OUT-1:0]   out_d;

    pla_eval #(
        .N_IN   (N_IN),
        .N_TERM (N_TERM),
        .N_OUT  (N_OUT)
    ) u_eval (
        .fuse_i (active_q),
        .in_i   (pla_in),
        .out_o  (out_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            done_q <= 1'b0;
            out_q  <= out_d;
            unique case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_q  <= LOAD;
                        cnt_q    <= '0;
                        par_q    <= 1'b0;
                        shadow_q <= '0;
                        err_q    <= 1'b0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart outranks a bit offered in the same cycle
                    if (cfg_start) begin
                        cnt_q    <= '0;
                        par_q    <= 1'b0;
                        shadow_q <= '0;
                        err_q    <= 1'b0;
                    end else if (cfg_valid) begin
                        par_q <= par_q ^ cfg_bit;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q < CW'(FW)) shadow_q[cnt_q] <= cfg_bit;
                        if (cnt_q == CW'(FRW - 1)) begin
                            state_q <= CHECK;
                            ready_q <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    if (!par_q) active_q <= shadow_q;
                    else        err_q    <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign busy      = busy_q;
    assign pla_out   = out_q;

endmodule
